// File: rtl/decode_stage_sb.sv
// rtl/decode_stage_sb.sv - decode stage with register file, busy-bit scoreboard and writeback port
//
// Purpose:
//   Splits an instruction into opcode | isel | r0 | r1 | imm, reads its operands
//   from a 2**W_RD x W_OPR register file, and issues it one cycle later.
//   Instructions wait while an operand or the destination is still being produced,
//   which a busy-bit scoreboard tracks (one bit per register).
//
// Optional feature:
//   DECODE_STAGE_SB_BYPASS_EN - when defined, the writeback data is forwarded
//   into operands read in the same cycle. This also lifts the hazard for those
//   operands. When undefined, such a match stalls one cycle and the instruction
//   then reads the register file.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   v_i, inst_i           incoming instruction and its valid
//   stall_i / stall_o     downstream stall in / upstream stall out (combinational)
//   v_o, opecode_o,       issued instruction: valid, opcode, operands,
//   opr0_o, opr1_o,       destination register and its write flag
//   wb_r_o, wb_en_o
//   wb_i, wb_r_i,         writeback strobe, register and data: writes the register
//   result_i              file and clears the register's busy bit

`timescale 1ns/1ps

module decode_stage_sb #(
  parameter int W_OPC = 4,
  parameter int W_RD  = 4,
  parameter int W_IMM = 19,
  parameter int W_OPR = 32,
  localparam int WORD = W_OPC + 1 + 2*W_RD + W_IMM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic [WORD-1:0]  inst_i,
  input  logic             stall_i,
  output logic             stall_o,
  output logic             v_o,
  output logic [W_OPC-1:0] opecode_o,
  output logic [W_OPR-1:0] opr0_o,
  output logic [W_OPR-1:0] opr1_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic             wb_en_o,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [W_OPR-1:0] result_i
);

  localparam int NREG = 2**W_RD;

  logic [W_OPC-1:0] w_opc;
  logic             w_isel;
  logic [W_RD-1:0]  w_r0;
  logic [W_RD-1:0]  w_r1;
  logic [W_IMM-1:0] w_imm;

  assign {w_opc, w_isel, w_r0, w_r1, w_imm} = inst_i;

  logic [W_OPR-1:0] r_rf [NREG];
  logic [NREG-1:0]  r_busy;

  logic             w_writes;
  logic             w_busy0;
  logic             w_busy1;
  logic [W_OPR-1:0] w_rd0;
  logic [W_OPR-1:0] w_rd1;
  logic [W_OPR-1:0] w_opr1;
  logic             w_hazard;
  logic             w_issue;

  // Opcode 0 is a NOP: it never claims its destination.
  assign w_writes = |w_opc;

`ifdef DECODE_STAGE_SB_BYPASS_EN
  logic w_byp0;
  logic w_byp1;

  // A writeback landing this cycle both supplies the value and retires the
  // busy bit, so the matching operand neither waits nor reads stale data.
  assign w_byp0  = wb_i && (wb_r_i == w_r0);
  assign w_byp1  = wb_i && (wb_r_i == w_r1);
  assign w_busy0 = r_busy[w_r0] & ~w_byp0;
  assign w_busy1 = r_busy[w_r1] & ~w_byp1;
  assign w_rd0   = w_byp0 ? result_i : r_rf[w_r0];
  assign w_rd1   = w_byp1 ? result_i : r_rf[w_r1];
`else
  // Read-before-write: a same-cycle writeback is seen only on the next cycle.
  assign w_busy0 = r_busy[w_r0];
  assign w_busy1 = r_busy[w_r1];
  assign w_rd0   = r_rf[w_r0];
  assign w_rd1   = r_rf[w_r1];
`endif

  assign w_opr1 = w_isel ? {{(W_OPR-W_IMM){w_imm[W_IMM-1]}}, w_imm} : w_rd1;

  // busy[r0] covers both reading r0 and overwriting it; r1 matters only when
  // operand 1 comes from the register file.
  assign w_hazard = v_i & (w_busy0 | (~w_isel & w_busy1));
  assign stall_o  = stall_i | w_hazard;
  assign w_issue  = v_i & ~w_hazard & ~stall_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_i) begin
      r_rf[wb_r_i] <= result_i;
    end
  end

  // Clear then set: when an issue claims the register being written back on
  // the same edge, the later assignment (the set) wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (wb_i) r_busy[wb_r_i] <= 1'b0;
      if (w_issue && w_writes) r_busy[w_r0] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_o       <= 1'b0;
      opecode_o <= '0;
      opr0_o    <= '0;
      opr1_o    <= '0;
      wb_r_o    <= '0;
      wb_en_o   <= 1'b0;
    end else if (!stall_i) begin
      v_o <= w_issue;
      if (w_issue) begin
        opecode_o <= w_opc;
        opr0_o    <= w_rd0;
        opr1_o    <= w_opr1;
        wb_r_o    <= w_r0;
        wb_en_o   <= w_writes;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_sb.sv
// tb/tb_decode_stage_sb.sv - scoreboard-driven self-checking bench for decode_stage_sb

`timescale 1ns/1ps

module tb_decode_stage_sb;

  localparam int W_OPC = 4;
  localparam int W_RD  = 4;
  localparam int W_IMM = 19;
  localparam int W_OPR = 32;
  localparam int WORD  = W_OPC + 1 + 2*W_RD + W_IMM;
  localparam int EW    = W_OPC + 2*W_OPR + W_RD + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             v_i;
  logic [WORD-1:0]  inst_i;
  logic             stall_i;
  logic             stall_o;
  logic             v_o;
  logic [W_OPC-1:0] opecode_o;
  logic [W_OPR-1:0] opr0_o;
  logic [W_OPR-1:0] opr1_o;
  logic [W_RD-1:0]  wb_r_o;
  logic             wb_en_o;
  logic             wb_i;
  logic [W_RD-1:0]  wb_r_i;
  logic [W_OPR-1:0] result_i;

  decode_stage_sb #(.W_OPC(W_OPC), .W_RD(W_RD), .W_IMM(W_IMM), .W_OPR(W_OPR)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .stall_i(stall_i),
    .stall_o(stall_o), .v_o(v_o), .opecode_o(opecode_o), .opr0_o(opr0_o),
    .opr1_o(opr1_o), .wb_r_o(wb_r_o), .wb_en_o(wb_en_o), .wb_i(wb_i),
    .wb_r_i(wb_r_i), .result_i(result_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0]    exp_q [$];
  logic [EW-1:0]    e;
  logic [EW-1:0]    held;
  logic [W_OPR-1:0] m_rf [16];
  logic [EW-1:0]    act;

  assign act = {opecode_o, opr0_o, opr1_o, wb_r_o, wb_en_o};

  function automatic logic [WORD-1:0] mkinst(input logic [3:0] opc, input logic isel,
                                             input logic [3:0] r0, input logic [3:0] r1,
                                             input logic [18:0] imm);
    return {opc, isel, r0, r1, imm};
  endfunction

  function automatic logic [EW-1:0] mkexp(input logic [3:0] opc, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] wr,
                                          input logic wen);
    return {opc, a, b, wr, wen};
  endfunction

  // An empty queue yields X, which can never match a 2-state DUT output.
  function automatic logic [EW-1:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  task automatic drive(input logic v, input logic [WORD-1:0] inst, input logic st,
                       input logic wb, input logic [3:0] wr, input logic [31:0] res);
    v_i = v; inst_i = inst; stall_i = st; wb_i = wb; wb_r_i = wr; result_i = res;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    cyc(); cyc();
    n_checks++;
    if ({v_o, act} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {v_o, act});
    end
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    cyc();
  endtask

  task automatic test_basic_issue();
    drive(1'b0, '0, 1'b0, 1'b1, 4'd2, 32'd5); cyc(); m_rf[2] = 32'd5;
    drive(1'b0, '0, 1'b0, 1'b1, 4'd3, 32'd7); cyc(); m_rf[3] = 32'd7;
    drive(1'b1, mkinst(4'd1, 1'b0, 4'd2, 4'd3, 19'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_no_stall: got %b expected 0", stall_o);
    end
    exp_q.push_back(mkexp(4'd1, m_rf[2], m_rf[3], 4'd2, 1'b1));
    cyc(); idle();
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL basic_issue: got v=%b %h expected v=1 %h", v_o, act, e);
    end
    // Probe busy bits through stall_o with a NOP that is withdrawn before the edge.
    drive(1'b1, mkinst(4'd0, 1'b1, 4'd2, 4'd0, 19'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy2_set: stall got %b expected 1", stall_o);
    end
    inst_i = mkinst(4'd0, 1'b1, 4'd3, 4'd0, 19'd0);
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy3_clear: stall got %b expected 0", stall_o);
    end
    v_i = 1'b0;
  endtask

  task automatic test_raw_writeback();
    logic [WORD-1:0] ins;
    ins = mkinst(4'd2, 1'b0, 4'd5, 4'd2, 19'd0);
    drive(1'b1, ins, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (stall_o !== 1'b1) begin
        n_fail++; $display("FAIL raw_stall[%0d]: got %b expected 1", k, stall_o);
      end
      cyc();
      n_checks++;
      if (v_o !== 1'b0) begin
        n_fail++; $display("FAIL raw_bubble[%0d]: v_o got %b expected 0", k, v_o);
      end
    end
    drive(1'b1, ins, 1'b0, 1'b1, 4'd2, 32'd9);
    #1;
`ifdef DECODE_STAGE_SB_BYPASS_EN
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL raw_bypass_nostall: got %b expected 0", stall_o);
    end
    exp_q.push_back(mkexp(4'd2, m_rf[5], 32'd9, 4'd5, 1'b1));
    cyc(); m_rf[2] = 32'd9; idle();
`else
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL raw_wb_cycle_stall: got %b expected 1", stall_o);
    end
    cyc(); m_rf[2] = 32'd9;
    drive(1'b1, ins, 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL raw_after_wb_nostall: got %b expected 0", stall_o);
    end
    exp_q.push_back(mkexp(4'd2, m_rf[5], 32'd9, 4'd5, 1'b1));
    cyc(); idle();
`endif
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL raw_issue: got v=%b %h expected v=1 %h", v_o, act, e);
    end
  endtask

  task automatic test_back_to_back_imm();
    drive(1'b1, mkinst(4'd3, 1'b1, 4'd6, 4'd0, 19'h7FFFF), 1'b0, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mkexp(4'd3, m_rf[6], 32'hFFFF_FFFF, 4'd6, 1'b1));
    cyc();
    drive(1'b1, mkinst(4'd4, 1'b1, 4'd7, 4'd0, 19'h3FFFF), 1'b0, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mkexp(4'd4, m_rf[7], 32'h0003_FFFF, 4'd7, 1'b1));
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL imm_neg: got v=%b %h expected v=1 %h", v_o, act, e);
    end
    cyc(); idle();
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL imm_pos: got v=%b %h expected v=1 %h", v_o, act, e);
    end
  endtask

  task automatic test_nop();
    drive(1'b1, mkinst(4'd0, 1'b1, 4'd11, 4'd0, 19'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mkexp(4'd0, m_rf[11], 32'd0, 4'd11, 1'b0));
    cyc(); idle();
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL nop_issue: got v=%b %h expected v=1 %h", v_o, act, e);
    end
    drive(1'b1, mkinst(4'd0, 1'b1, 4'd11, 4'd0, 19'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL nop_no_busy: stall got %b expected 0", stall_o);
    end
    v_i = 1'b0;
  endtask

  task automatic test_stall_hold();
    logic [WORD-1:0] ins_b;
    drive(1'b1, mkinst(4'd5, 1'b0, 4'd8, 4'd3, 19'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mkexp(4'd5, m_rf[8], m_rf[3], 4'd8, 1'b1));
    cyc();
    held = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== held) begin
      n_fail++; $display("FAIL stall_pre_issue: got v=%b %h expected v=1 %h", v_o, act, held);
    end
    ins_b = mkinst(4'd6, 1'b1, 4'd9, 4'd0, 19'd5);
    drive(1'b1, ins_b, 1'b1, 1'b0, 4'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (stall_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_o_during[%0d]: got %b expected 1", k, stall_o);
      end
      cyc();
      n_checks++;
      if ({v_o, act} !== {1'b1, held}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", k, {v_o, act}, {1'b1, held});
      end
    end
    stall_i = 1'b0;
    #1;
    // r0=9 would hazard if the stalled cycles had marked it busy.
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_no_busy_set: stall got %b expected 0", stall_o);
    end
    exp_q.push_back(mkexp(4'd6, m_rf[9], 32'd5, 4'd9, 1'b1));
    cyc(); idle();
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL stall_release_issue: got v=%b %h expected v=1 %h", v_o, act, e);
    end
    cyc();
    n_checks++;
    if (v_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_issue_once: v_o got %b expected 0", v_o);
    end
  endtask

  task automatic test_same_edge_set_wins();
    drive(1'b1, mkinst(4'd7, 1'b1, 4'd4, 4'd0, 19'd1), 1'b0, 1'b1, 4'd4, 32'h44);
`ifdef DECODE_STAGE_SB_BYPASS_EN
    exp_q.push_back(mkexp(4'd7, 32'h44, 32'd1, 4'd4, 1'b1));
`else
    exp_q.push_back(mkexp(4'd7, m_rf[4], 32'd1, 4'd4, 1'b1));
`endif
    cyc(); m_rf[4] = 32'h44; idle();
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL same_edge_issue: got v=%b %h expected v=1 %h", v_o, act, e);
    end
    drive(1'b1, mkinst(4'd0, 1'b1, 4'd4, 4'd0, 19'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_busy4: stall got %b expected 1", stall_o);
    end
  endtask

  task automatic test_reset_mid();
    // v_o=1, busy[4]=1 and a hazarding instruction are all pending here.
    inst_i = mkinst(4'd1, 1'b0, 4'd4, 4'd4, 19'd0);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({v_o, act} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", {v_o, act});
    end
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_hazard: stall got %b expected 0", stall_o);
    end
    idle();
    exp_q.delete();
    @(negedge clk);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    drive(1'b0, '0, 1'b0, 1'b1, 4'd1, 32'h123); cyc(); m_rf[1] = 32'h123;
    drive(1'b1, mkinst(4'd1, 1'b0, 4'd2, 4'd1, 19'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mkexp(4'd1, m_rf[2], m_rf[1], 4'd2, 1'b1));
    cyc(); idle();
    e = pop_exp();
    n_checks++;
    if (v_o !== 1'b1 || act !== e) begin
      n_fail++; $display("FAIL reset_rf_cleared: got v=%b %h expected v=1 %h", v_o, act, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_raw_writeback();
    test_back_to_back_imm();
    test_nop();
    test_stall_hold();
    test_same_edge_set_wins();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
